// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES MixColumns block: FSM and mode
// encodings, GF(2^8) constant multipliers and state column addressing.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        MODE_FWD = 1'b0,
        MODE_INV = 1'b1
    } mode_e;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gf_mulb(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_muld(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gf_mule(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // Column c occupies bits [127-32c -: 32]; returned value is its LSB index.
    function automatic logic [6:0] col_lsb(input logic [1:0] idx);
        return 7'(7'd96 - {idx, 5'd0});
    endfunction

endpackage

// File: rtl/aes_mixw_dual.sv
// Combinational single-word MixColumns / InvMixColumns; byte 0 is the MSB.
module aes_mixw_dual
    import aes_pkg::*;
(
    input  logic [31:0] w_i,
    input  logic        mode_i,
    output logic [31:0] w_o
);

    logic [7:0] a0, a1, a2, a3;
    logic [31:0] fwd, inv;

    assign a0 = w_i[31:24];
    assign a1 = w_i[23:16];
    assign a2 = w_i[15:8];
    assign a3 = w_i[7:0];

    assign fwd = {
        gf_mul2(a0) ^ gf_mul3(a1) ^ a2          ^ a3,
        a0          ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3,
        a0          ^ a1          ^ gf_mul2(a2) ^ gf_mul3(a3),
        gf_mul3(a0) ^ a1          ^ a2          ^ gf_mul2(a3)
    };

    assign inv = {
        gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3),
        gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3),
        gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3),
        gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3)
    };

    assign w_o = (mode_i == MODE_INV) ? inv : fwd;

endmodule

// File: rtl/aes_mixcol_iter.sv
// Iterative MixColumns over a 128-bit AES state, COLS_PER_CYCLE columns per
// BUSY cycle, with valid/ready handshakes on both sides.
module aes_mixcol_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic         mode_i,
    input  logic [127:0] state_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] state_o
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $fatal(1, "aes_mixcol_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // Counter value at the start of the final BUSY cycle (the one covering column 3).
    localparam logic [1:0] LAST_K = 2'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] STEP   = 2'(COLS_PER_CYCLE);

    state_e         fsm_q, fsm_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [127:0]   work_q, work_d;
    mode_e          mode_q, mode_d;

    logic [COLS_PER_CYCLE-1:0][31:0] lane_in, lane_out;

    for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_lane
        assign lane_in[i] = work_q[col_lsb(cnt_q + 2'(i)) +: 32];

        aes_mixw_dual u_mixw (
            .w_i    (lane_in[i]),
            .mode_i (mode_q),
            .w_o    (lane_out[i])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q  <= ST_IDLE;
            cnt_q  <= 2'd0;
            work_q <= 128'd0;
            mode_q <= MODE_FWD;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            work_q <= work_d;
            mode_q <= mode_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        mode_d      = mode_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;

        unique case (fsm_q)
            ST_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    work_d = state_i;
                    mode_d = mode_e'(mode_i);
                    cnt_d  = 2'd0;
                    fsm_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                    work_d[col_lsb(cnt_q + 2'(i)) +: 32] = lane_out[i];
                end
                // 2-bit add wraps to 0 once column 3 has been covered.
                cnt_d = cnt_q + STEP;
                if (cnt_q == LAST_K) begin
                    fsm_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    assign state_o = work_q;

endmodule
